i2c_write_sequencer: RTL and testbench

//   Shares one byte-level I2C master engine between NUM_REQ register-write requesters.

---
 rtl/i2c_write_sequencer.sv | 176 +++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_sequencer.sv
// Round-robin sequencer sharing one byte-level I2C master engine
// among NUM_REQ register-write requesters, with NACK retry.
module i2c_write_sequencer #(
  parameter int NUM_REQ    = 2,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 64
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [7*NUM_REQ-1:0] Req_Dev,
  input  logic [8*NUM_REQ-1:0] Req_Reg,
  input  logic [8*NUM_REQ-1:0] Req_Data,
  output logic [NUM_REQ-1:0]   Grant,
  output logic [NUM_REQ-1:0]   Done,
  output logic                 Error,
  output logic                 Busy,
  output logic                 Eng_Valid,
  input  logic                 Eng_Ready,
  output logic                 Eng_Start,
  output logic                 Eng_Stop,
  output logic [7:0]           Eng_Byte,
  input  logic                 Eng_Done,
  input  logic                 Eng_Nack
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, WAIT_ADDR, REG, WAIT_REG,
    DATA, WAIT_DATA, NACK_GAP, GAP, FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  own_q, own_d;
  logic [6:0]     dev_q, dev_d;
  logic [7:0]     reg_q, reg_d;
  logic [7:0]     data_q, data_d;
  logic [3:0]     retry_q, retry_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           err_q, err_d;
  logic [NUM_REQ-1:0] own_oh;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      own_q   <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  assign own_oh = NUM_REQ'(1) << own_q;
  assign Busy   = (state_q != IDLE);
  assign Grant  = Busy ? own_oh : '0;

  always_comb begin
    int   j;
    logic found;
    j         = 0;
    found     = 1'b0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    data_d    = data_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    err_d     = err_q;
    Done      = '0;
    Error     = 1'b0;
    Eng_Valid = 1'b0;
    Eng_Start = 1'b0;
    Eng_Stop  = 1'b0;
    Eng_Byte  = 8'h00;
    unique case (state_q)
      IDLE: begin
        // Search starts one past the last owner, wrapping.
        for (int i = 1; i <= NUM_REQ; i++) begin
          j = int'(ptr_q) + i;
          if (j >= NUM_REQ) j = j - NUM_REQ;
          if (!found && Req[j]) begin
            found  = 1'b1;
            own_d  = IW'(j);
            ptr_d  = IW'(j);
            dev_d  = Req_Dev[j*7 +: 7];
            reg_d  = Req_Reg[j*8 +: 8];
            data_d = Req_Data[j*8 +: 8];
          end
        end
        if (found) begin
          state_d = ADDR;
          retry_d = '0;
          err_d   = 1'b0;
        end
      end
      ADDR: begin
        Eng_Valid = 1'b1;
        Eng_Start = 1'b1;
        Eng_Byte  = {dev_q, 1'b0};
        if (Eng_Ready) state_d = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        if (Eng_Done) state_d = Eng_Nack ? NACK_GAP : REG;
      end
      REG: begin
        Eng_Valid = 1'b1;
        Eng_Byte  = reg_q;
        if (Eng_Ready) state_d = WAIT_REG;
      end
      WAIT_REG: begin
        if (Eng_Done) state_d = Eng_Nack ? NACK_GAP : DATA;
      end
      DATA: begin
        Eng_Valid = 1'b1;
        Eng_Stop  = 1'b1;
        Eng_Byte  = data_q;
        if (Eng_Ready) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (Eng_Done) state_d = Eng_Nack ? NACK_GAP : FINISH;
      end
      NACK_GAP: begin
        // This cycle is the first of the idle gap.
        if (retry_q == 4'(MAX_RETRY)) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          retry_d = retry_q + 4'd1;
          if (GAP_CYCLES <= 1) begin
            state_d = ADDR;
          end else begin
            gap_d   = GW'(GAP_CYCLES - 1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = ADDR;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      FINISH: begin
        Done    = own_oh;
        Error   = err_q;
        retry_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench: expected engine bytes and Done events are queued
// by stimulus and popped by a monitor when the DUT presents them.
module tb_i2c_write_sequencer;

  localparam int NR  = 2;
  localparam int MR  = 3;
  localparam int GAP = 64;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic [NR-1:0] Req;
  logic [7*NR-1:0] Req_Dev;
  logic [8*NR-1:0] Req_Reg;
  logic [8*NR-1:0] Req_Data;
  logic [NR-1:0] Grant;
  logic [NR-1:0] Done;
  logic          Error;
  logic          Busy;
  logic          Eng_Valid;
  logic          Eng_Ready;
  logic          Eng_Start;
  logic          Eng_Stop;
  logic [7:0]    Eng_Byte;
  logic          Eng_Done;
  logic          Eng_Nack;

  i2c_write_sequencer #(
    .NUM_REQ(NR), .MAX_RETRY(MR), .GAP_CYCLES(GAP)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Req(Req), .Req_Dev(Req_Dev),
    .Req_Reg(Req_Reg), .Req_Data(Req_Data),
    .Grant(Grant), .Done(Done), .Error(Error),
    .Busy(Busy), .Eng_Valid(Eng_Valid),
    .Eng_Ready(Eng_Ready), .Eng_Start(Eng_Start),
    .Eng_Stop(Eng_Stop), .Eng_Byte(Eng_Byte),
    .Eng_Done(Eng_Done), .Eng_Nack(Eng_Nack)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] exp_cmd[$];
  logic [2:0] exp_done[$];

  int   nack_addr_left = 0;
  bit   nack_data_all  = 0;
  int   stall_left     = 0;
  bit   stall_on       = 0;
  logic [7:0] stall_byte = 8'h00;
  int   pend      = 0;
  bit   pend_nack = 0;
  bit   reg_acc   = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push_txn(logic [6:0] dv, logic [7:0] rg,
                          logic [7:0] dt);
    exp_cmd.push_back({2'b10, dv, 1'b0});
    exp_cmd.push_back({2'b00, rg});
    exp_cmd.push_back({2'b01, dt});
  endtask

  task automatic set_req(int i, logic [6:0] dv,
                         logic [7:0] rg, logic [7:0] dt);
    Req_Dev[i*7 +: 7]  = dv;
    Req_Reg[i*8 +: 8]  = rg;
    Req_Data[i*8 +: 8] = dt;
  endtask

  task automatic wait_done(int limit);
    bit got;
    got = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge Clock);
      #1;
      if (|Done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    Reset_n        = 1'b0;
    Req            = '0;
    nack_addr_left = 0;
    nack_data_all  = 0;
    stall_left     = 0;
    repeat (2) @(negedge Clock);
    chk("reset_outs",
        {Grant, Done, Error, Busy, Eng_Valid,
         Eng_Start, Eng_Stop, Eng_Byte}, 0);
    Reset_n = 1'b1;
  endtask

  // Engine model: accepts on Valid&&Ready, answers 3 cycles later.
  initial begin
    Eng_Ready = 1'b1;
    Eng_Done  = 1'b0;
    Eng_Nack  = 1'b0;
    forever begin
      @(negedge Clock);
      Eng_Done = 1'b0;
      Eng_Nack = 1'b0;
      if (!Reset_n) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          Eng_Done = 1'b1;
          Eng_Nack = pend_nack;
        end
      end
      Eng_Ready = 1'b1;
      if (Reset_n && stall_left > 0 &&
          (stall_on || (Eng_Valid && !Eng_Start
                        && !Eng_Stop))) begin
        stall_on  = 1;
        Eng_Ready = 1'b0;
        stall_left--;
        chk("stall_hold",
            {Eng_Valid, Eng_Start, Eng_Stop, Eng_Byte},
            {3'b100, stall_byte});
      end
      if (stall_left == 0) stall_on = 0;
      #1;
      if (Reset_n && Eng_Valid && Eng_Ready) begin
        pend      = 3;
        pend_nack = 0;
        if (Eng_Start && nack_addr_left > 0) begin
          pend_nack = 1;
          nack_addr_left--;
        end
        if (Eng_Stop) pend_nack = nack_data_all;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    int   cyc;
    int   nack_cyc;
    bit   gap_pend;
    logic [9:0] ec;
    logic [2:0] ed;
    cyc = 0;
    nack_cyc = 0;
    gap_pend = 0;
    forever begin
      @(negedge Clock);
      #2;
      cyc++;
      if (!Reset_n) begin
        gap_pend = 0;
        continue;
      end
      if (Eng_Done && Eng_Nack) begin
        nack_cyc = cyc;
        gap_pend = 1;
      end
      if (Eng_Valid && Eng_Ready) begin
        if (Eng_Start && gap_pend) begin
          n_chk++;
          if (cyc - nack_cyc < GAP + 1 ||
              cyc - nack_cyc > GAP + 2) begin
            n_fail++;
            $display("FAIL retry_gap: got %0d need %0d..%0d",
                     cyc - nack_cyc, GAP + 1, GAP + 2);
          end
          gap_pend = 0;
        end
        if (!Eng_Start && !Eng_Stop) reg_acc = 1;
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected",
              {Eng_Start, Eng_Stop, Eng_Byte}, 0);
        end else begin
          ec = exp_cmd.pop_front();
          chk("cmd", {Eng_Start, Eng_Stop, Eng_Byte}, ec);
        end
      end
      if ((|Done) || Error) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", {Done, Error}, 0);
        end else begin
          ed = exp_done.pop_front();
          chk("done_err", {Done, Error}, ed);
        end
        chk("grant_at_done", Grant, Done);
        chk("busy_at_done", Busy, 1);
      end
    end
  end

  initial begin
    bit seen;
    Reset_n  = 1'b0;
    Req      = '0;
    Req_Dev  = '0;
    Req_Reg  = '0;
    Req_Data = '0;
    #1;
    chk("reset_async",
        {Grant, Done, Error, Busy, Eng_Valid,
         Eng_Start, Eng_Stop, Eng_Byte}, 0);
    do_reset();

    // 1: plain write, all ACK
    set_req(0, 7'h1A, 8'h05, 8'hC3);
    push_txn(7'h1A, 8'h05, 8'hC3);
    exp_done.push_back({2'b01, 1'b0});
    Req = 2'b01;
    wait_done(200);
    Req = 2'b00;
    repeat (3) @(negedge Clock);

    // 2: both requesting -> strict alternation
    do_reset();
    set_req(0, 7'h10, 8'hA0, 8'hB0);
    set_req(1, 7'h20, 8'hA1, 8'hB1);
    push_txn(7'h10, 8'hA0, 8'hB0);
    push_txn(7'h20, 8'hA1, 8'hB1);
    push_txn(7'h10, 8'hA0, 8'hB0);
    exp_done.push_back({2'b01, 1'b0});
    exp_done.push_back({2'b10, 1'b0});
    exp_done.push_back({2'b01, 1'b0});
    Req = 2'b11;
    repeat (3) wait_done(200);
    Req = 2'b00;
    repeat (3) @(negedge Clock);

    // 3: two address NACKs then success
    do_reset();
    set_req(0, 7'h1A, 8'h05, 8'hC3);
    nack_addr_left = 2;
    exp_cmd.push_back({2'b10, 8'h34});
    exp_cmd.push_back({2'b10, 8'h34});
    push_txn(7'h1A, 8'h05, 8'hC3);
    exp_done.push_back({2'b01, 1'b0});
    Req = 2'b01;
    wait_done(1000);
    Req = 2'b00;
    repeat (3) @(negedge Clock);

    // 4: data always NACKed -> MAX_RETRY+1 attempts, error
    do_reset();
    set_req(0, 7'h50, 8'h11, 8'h22);
    nack_data_all = 1;
    for (int a = 0; a <= MR; a++)
      push_txn(7'h50, 8'h11, 8'h22);
    exp_done.push_back({2'b01, 1'b1});
    Req = 2'b01;
    wait_done(2000);
    Req = 2'b00;
    repeat (3) @(negedge Clock);

    // 5: engine stalls the register byte for 10 cycles
    do_reset();
    set_req(0, 7'h2B, 8'h7E, 8'h99);
    stall_byte = 8'h7E;
    stall_left = 10;
    push_txn(7'h2B, 8'h7E, 8'h99);
    exp_done.push_back({2'b01, 1'b0});
    Req = 2'b01;
    wait_done(300);
    Req = 2'b00;
    chk("stall_consumed", stall_left, 0);
    repeat (3) @(negedge Clock);

    // 6: reset during WAIT_REG, then re-grant from ADDR
    do_reset();
    set_req(0, 7'h1A, 8'h05, 8'hC3);
    reg_acc = 0;
    exp_cmd.push_back({2'b10, 8'h34});
    exp_cmd.push_back({2'b00, 8'h05});
    Req  = 2'b01;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clock);
      #3;
      if (reg_acc) begin
        seen = 1;
        break;
      end
    end
    chk("reach_wait_reg", seen, 1);
    @(negedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("rst_mid_txn", {Grant, Busy, Eng_Valid}, 0);
    repeat (2) @(negedge Clock);
    push_txn(7'h1A, 8'h05, 8'hC3);
    exp_done.push_back({2'b01, 1'b0});
    Reset_n = 1'b1;
    wait_done(200);
    Req = 2'b00;
    repeat (5) @(negedge Clock);

    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
